// File: rtl/uart_msg_sequencer_pkg.sv
// Shared definitions for the UART message sequencer: FSM state encoding and
// the ASCII characters that message-formatting logic commonly needs.
package uart_msg_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WLO   = 3'd2,
        ST_WHI   = 3'd3,
        ST_TERM  = 3'd4,
        ST_FIN   = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    localparam logic [7:0] ASCII_NUL    = 8'h00;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_LBRACE = 8'h7B;
    localparam logic [7:0] ASCII_HASH   = 8'h23;

endpackage

// File: rtl/uart_msg_sequencer_if.sv
// Byte handshake between the sequencer (master) and the UART transmitter (slave).
interface uart_msg_sequencer_if;

    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_ready;

    modport master (output tx_data, output tx_send, input tx_ready);
    modport slave  (input tx_data, input tx_send, output tx_ready);

endinterface

// File: rtl/uart_msg_sequencer_msg_byte_mux.sv
// Shadow copy of the message and its clamped length, plus the byte selector
// that picks shadow byte idx (byte 0 lives in the most significant lane).
module msg_byte_mux
    import uart_msg_sequencer_pkg::*;
#(
    parameter int MAX_BYTES = 32,
    parameter int LEN_W     = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   capture,
    input  logic [8*MAX_BYTES-1:0] msg_in,
    input  logic [LEN_W-1:0]       msg_len,
    input  logic [LEN_W-1:0]       idx,
    output logic [LEN_W-1:0]       cap_len,
    output logic [LEN_W-1:0]       len_q,
    output logic [7:0]             byte_out
);

    logic [8*MAX_BYTES-1:0] shadow_q;
    logic [8*MAX_BYTES-1:0] shadow_d;
    logic [LEN_W-1:0]       len_d;

    // cap_len is what the FSM would capture right now, so it can decide on a zero length immediately.
    always_comb begin
        cap_len  = (msg_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : msg_len;
        shadow_d = capture ? msg_in : shadow_q;
        len_d    = capture ? cap_len : len_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            len_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            len_q    <= len_d;
        end
    end

    always_comb begin
        byte_out = 8'h00;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (idx == LEN_W'(k)) begin
                byte_out = shadow_q[8*(MAX_BYTES-k)-1 -: 8];
            end
        end
    end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Streams a captured ASCII message (optionally terminated, optionally repeated
// with an idle gap) into a UART transmitter's send/ready handshake.
module uart_msg_sequencer
    import uart_msg_sequencer_pkg::*;
#(
    parameter int         MAX_BYTES = 32,
    parameter int         LEN_W     = 6,
    parameter int         TERM_EN   = 1,
    parameter logic [7:0] TERM_BYTE = 8'h00,
    parameter int         GAP_TICKS = 0,
    parameter int         GAP_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      start,
    input  logic                      repeat_mode,
    input  logic [LEN_W-1:0]          msg_len,
    input  logic [8*MAX_BYTES-1:0]    msg_in,
    uart_msg_sequencer_if.master      tx,
    output logic                      busy,
    output logic                      done,
    output logic [LEN_W-1:0]          byte_idx
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             term_q, term_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tx_send_q, tx_send_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             recapture;
    logic             capture;
    logic [LEN_W-1:0] cap_len;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] last_idx;
    logic [7:0]       cur_byte;

    msg_byte_mux #(
        .MAX_BYTES (MAX_BYTES),
        .LEN_W     (LEN_W)
    ) u_mux (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .msg_in   (msg_in),
        .msg_len  (msg_len),
        .idx      (idx_q),
        .cap_len  (cap_len),
        .len_q    (len_q),
        .byte_out (cur_byte)
    );

    assign last_idx = len_q - LEN_W'(1);
    assign capture  = recapture & en;

    // term_q marks that the handshake in WLO/WHI belongs to the terminator, not a data byte.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        term_d    = term_q;
        busy_d    = busy_q;
        tx_data_d = tx_data_q;
        tx_send_d = 1'b0;
        done_d    = 1'b0;
        recapture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) recapture = 1'b1;
            end
            ST_ISSUE: begin
                if (tx.tx_ready) begin
                    tx_data_d = cur_byte;
                    tx_send_d = 1'b1;
                    state_d   = ST_WLO;
                end
            end
            ST_WLO: begin
                if (!tx.tx_ready) state_d = ST_WHI;
            end
            ST_WHI: begin
                if (tx.tx_ready) begin
                    if (term_q || (idx_q == last_idx && TERM_EN == 0)) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else if (idx_q == last_idx) begin
                        state_d = ST_TERM;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_TERM: begin
                if (tx.tx_ready) begin
                    tx_data_d = TERM_BYTE;
                    tx_send_d = 1'b1;
                    term_d    = 1'b1;
                    state_d   = ST_WLO;
                end
            end
            ST_FIN: begin
                if (repeat_mode) begin
                    if (GAP_TICKS > 0) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        recapture = 1'b1;
                    end
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_TICKS - 1)) recapture = 1'b1;
                else                                gap_d     = gap_q + GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // An empty message goes straight to the terminator, or completes with nothing sent.
        if (recapture) begin
            idx_d  = '0;
            gap_d  = '0;
            term_d = 1'b0;
            busy_d = 1'b1;
            if (cap_len == '0) begin
                if (TERM_EN != 0) begin
                    state_d = ST_TERM;
                end else begin
                    done_d = 1'b1;
                    if (state_q == ST_IDLE) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end else begin
                state_d = ST_ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            term_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_send_q <= 1'b0;
            tx_data_q <= 8'h00;
        end else if (en) begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            term_q    <= term_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tx_send_q <= tx_send_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx.tx_data = tx_data_q;
    assign tx.tx_send = tx_send_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_idx   = idx_q;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Directed bench for uart_msg_sequencer: one terminated/gapped instance (a_) and
// one unterminated instance (b_), each fed by a uarttx model with a 3-cycle ready drop.
module tb_uart_msg_sequencer;
    import uart_msg_sequencer_pkg::*;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: TERM_EN=1, GAP_TICKS=5
    logic         rst_a = 1'b1;
    logic         a_en = 1'b1;
    logic         a_start = 1'b0;
    logic         a_repeat = 1'b0;
    logic [5:0]   a_len = '0;
    logic [255:0] a_msg = '0;
    logic         a_busy, a_done;
    logic [5:0]   a_byte_idx;
    logic         a_ready_q = 1'b1;
    logic         a_hold = 1'b0;
    int           a_cnt = 0;
    uart_msg_sequencer_if a_if ();
    assign a_if.tx_ready = a_ready_q & ~a_hold;

    uart_msg_sequencer #(
        .MAX_BYTES(32), .LEN_W(6), .TERM_EN(1), .TERM_BYTE(8'h00), .GAP_TICKS(5), .GAP_W(16)
    ) dut_a (
        .clk(clk), .rst(rst_a), .en(a_en), .start(a_start), .repeat_mode(a_repeat),
        .msg_len(a_len), .msg_in(a_msg), .tx(a_if), .busy(a_busy), .done(a_done),
        .byte_idx(a_byte_idx)
    );

    // Instance B: TERM_EN=0, GAP_TICKS=0
    logic         rst_b = 1'b1;
    logic         b_en = 1'b1;
    logic         b_start = 1'b0;
    logic         b_repeat = 1'b0;
    logic [5:0]   b_len = '0;
    logic [255:0] b_msg = '0;
    logic         b_busy, b_done;
    logic [5:0]   b_byte_idx;
    logic         b_ready_q = 1'b1;
    int           b_cnt = 0;
    uart_msg_sequencer_if b_if ();
    assign b_if.tx_ready = b_ready_q;

    uart_msg_sequencer #(
        .MAX_BYTES(32), .LEN_W(6), .TERM_EN(0), .TERM_BYTE(8'h00), .GAP_TICKS(0), .GAP_W(16)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(b_en), .start(b_start), .repeat_mode(b_repeat),
        .msg_len(b_len), .msg_in(b_msg), .tx(b_if), .busy(b_busy), .done(b_done),
        .byte_idx(b_byte_idx)
    );

    // Scoreboard state filled by the uarttx models
    logic [7:0] a_bytes[$];
    int         a_times[$];
    int         a_encyc = 0, a_send_pulses = 0, a_dones = 0, a_viol = 0;
    logic       a_prev_send = 1'b0;
    logic [5:0] a_max_idx = '0;
    logic [7:0] b_bytes[$];
    int         b_dones = 0;

    logic en_toggle = 1'b0;
    int   en_phase = 0;

    always @(negedge clk) begin
        if (en_toggle) begin
            en_phase = en_phase + 1;
            a_en = (en_phase % 4 == 0);
        end else begin
            a_en = 1'b1;
        end
    end

    // uarttx model A: accepts on send&&ready, then drops ready for 3 en-cycles
    always @(posedge clk) begin
        if (rst_a) begin
            a_ready_q <= 1'b1;
            a_cnt <= 0;
            a_prev_send = 1'b0;
        end else if (a_en) begin
            a_encyc = a_encyc + 1;
            if (a_if.tx_send) begin
                a_send_pulses = a_send_pulses + 1;
                if (!a_if.tx_ready) a_viol = a_viol + 1;
                if (a_prev_send) a_viol = a_viol + 1;
            end
            a_prev_send = a_if.tx_send;
            if (a_done) a_dones = a_dones + 1;
            if (a_if.tx_send && a_if.tx_ready) begin
                a_bytes.push_back(a_if.tx_data);
                a_times.push_back(a_encyc);
                a_ready_q <= 1'b0;
                a_cnt <= 3;
            end else if (!a_ready_q) begin
                if (a_cnt == 1) a_ready_q <= 1'b1;
                a_cnt <= a_cnt - 1;
            end
        end
        if (a_byte_idx > a_max_idx) a_max_idx = a_byte_idx;
    end

    always @(posedge clk) begin
        if (rst_b) begin
            b_ready_q <= 1'b1;
            b_cnt <= 0;
        end else if (b_en) begin
            if (b_done) b_dones = b_dones + 1;
            if (b_if.tx_send && b_if.tx_ready) begin
                b_bytes.push_back(b_if.tx_data);
                b_ready_q <= 1'b0;
                b_cnt <= 3;
            end else if (!b_ready_q) begin
                if (b_cnt == 1) b_ready_q <= 1'b1;
                b_cnt <= b_cnt - 1;
            end
        end
    end

    task automatic set_a_byte(input int k, input logic [7:0] c);
        a_msg[8*(32-k)-1 -: 8] = c;
    endtask

    task automatic clear_a();
        a_bytes.delete();
        a_times.delete();
        a_send_pulses = 0;
        a_dones = 0;
        a_viol = 0;
        a_max_idx = '0;
    endtask

    task automatic pulse_a_start();
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total += 5;
        if (a_if.tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx_data: got %h expected 00", a_if.tx_data); end
        if (a_if.tx_send !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_send: got %b expected 0", a_if.tx_send); end
        if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", a_busy); end
        if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", a_done); end
        if (a_byte_idx !== 6'd0) begin bad++; $display("[TB] FAIL reset_byte_idx: got %0d expected 0", a_byte_idx); end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        $display("[TB] basic two-byte message");
        a_msg = {256{1'b0}};
        for (int k = 0; k < 32; k++) set_a_byte(k, 8'h2E);
        set_a_byte(0, 8'h41);
        set_a_byte(1, 8'h42);
        a_len = 6'd2;
        clear_a();
        pulse_a_start();
        total += 3;
        if (a_if.tx_send !== 1'b0) begin bad++; $display("[TB] FAIL latency_early: got %b expected 0", a_if.tx_send); end
        if (a_busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_after_start: got %b expected 1", a_busy); end
        @(negedge clk);
        if (a_if.tx_send !== 1'b1 || a_if.tx_data !== 8'h41) begin
            bad++; $display("[TB] FAIL latency_send: got send=%b data=%h expected send=1 data=41", a_if.tx_send, a_if.tx_data);
        end
        for (int i = 0; i < 200 && a_dones < 1; i++) @(negedge clk);
        idle_cycles(10);
        total += 7;
        if (a_bytes.size() != 3) begin bad++; $display("[TB] FAIL basic_count: got %0d expected 3", a_bytes.size()); end
        if (a_bytes[0] !== 8'h41) begin bad++; $display("[TB] FAIL basic_b0: got %h expected 41", a_bytes[0]); end
        if (a_bytes[1] !== 8'h42) begin bad++; $display("[TB] FAIL basic_b1: got %h expected 42", a_bytes[1]); end
        if (a_bytes[2] !== ASCII_NUL) begin bad++; $display("[TB] FAIL basic_term: got %h expected 00", a_bytes[2]); end
        if (a_send_pulses != 3) begin bad++; $display("[TB] FAIL basic_sends: got %0d expected 3", a_send_pulses); end
        if (a_dones != 1) begin bad++; $display("[TB] FAIL basic_done: got %0d expected 1", a_dones); end
        if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_end: got %b expected 0", a_busy); end
    endtask

    task automatic test_clamp();
        int wrong;
        $display("[TB] length clamp 40 -> 32");
        for (int k = 0; k < 32; k++) set_a_byte(k, 8'h40 + 8'(k));
        a_len = 6'd40;
        clear_a();
        pulse_a_start();
        for (int i = 0; i < 1000 && a_dones < 1; i++) @(negedge clk);
        idle_cycles(10);
        wrong = 0;
        for (int k = 0; k < 32; k++) if (a_bytes[k] !== 8'h40 + 8'(k)) wrong++;
        total += 4;
        if (a_bytes.size() != 33) begin bad++; $display("[TB] FAIL clamp_count: got %0d expected 33", a_bytes.size()); end
        if (wrong != 0) begin bad++; $display("[TB] FAIL clamp_order: got %0d wrong bytes expected 0", wrong); end
        if (a_bytes[32] !== ASCII_NUL) begin bad++; $display("[TB] FAIL clamp_term: got %h expected 00", a_bytes[32]); end
        if (a_max_idx !== 6'd31) begin bad++; $display("[TB] FAIL clamp_max_idx: got %0d expected 31", a_max_idx); end
    endtask

    task automatic test_repeat_gap();
        $display("[TB] repeat mode with gap");
        set_a_byte(0, 8'h58);
        a_len = 6'd1;
        a_repeat = 1'b1;
        clear_a();
        pulse_a_start();
        for (int i = 0; i < 200 && a_dones < 1; i++) @(negedge clk);
        idle_cycles(2);
        set_a_byte(0, 8'h59);
        for (int i = 0; i < 200 && a_bytes.size() < 3; i++) @(negedge clk);
        a_repeat = 1'b0;
        for (int i = 0; i < 200 && a_dones < 2; i++) @(negedge clk);
        idle_cycles(20);
        total += 8;
        if (a_bytes.size() != 4) begin bad++; $display("[TB] FAIL rep_count: got %0d expected 4", a_bytes.size()); end
        if (a_bytes[0] !== 8'h58) begin bad++; $display("[TB] FAIL rep_b0: got %h expected 58", a_bytes[0]); end
        if (a_bytes[1] !== ASCII_NUL) begin bad++; $display("[TB] FAIL rep_t0: got %h expected 00", a_bytes[1]); end
        if (a_bytes[2] !== 8'h59) begin bad++; $display("[TB] FAIL rep_b1: got %h expected 59", a_bytes[2]); end
        if (a_bytes[3] !== ASCII_NUL) begin bad++; $display("[TB] FAIL rep_t1: got %h expected 00", a_bytes[3]); end
        if (a_times[2] - a_times[1] != 12) begin bad++; $display("[TB] FAIL rep_gap_spacing: got %0d expected 12", a_times[2] - a_times[1]); end
        if (a_dones != 2) begin bad++; $display("[TB] FAIL rep_dones: got %0d expected 2", a_dones); end
        if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL rep_busy_end: got %b expected 0", a_busy); end
    endtask

    task automatic test_reset_mid();
        $display("[TB] reset in the middle of byte 3");
        set_a_byte(0, ASCII_LBRACE);
        set_a_byte(1, ASCII_HASH);
        set_a_byte(2, 8'h31);
        set_a_byte(3, ASCII_LF);
        a_len = 6'd4;
        clear_a();
        pulse_a_start();
        for (int i = 0; i < 300 && !(a_if.tx_send === 1'b1 && a_byte_idx == 6'd3); i++) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        total += 6;
        if (a_if.tx_send !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_send: got %b expected 0", a_if.tx_send); end
        if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", a_busy); end
        if (a_byte_idx !== 6'd0) begin bad++; $display("[TB] FAIL rst_mid_idx: got %0d expected 0", a_byte_idx); end
        if (a_if.tx_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid_data: got %h expected 00", a_if.tx_data); end
        if (dut_a.state_q !== ST_IDLE) begin bad++; $display("[TB] FAIL rst_mid_state: got %0d expected 0", dut_a.state_q); end
        if (a_bytes.size() != 3) begin bad++; $display("[TB] FAIL rst_mid_partial: got %0d expected 3", a_bytes.size()); end
        rst_a = 1'b0;
        clear_a();
        pulse_a_start();
        for (int i = 0; i < 300 && a_dones < 1; i++) @(negedge clk);
        idle_cycles(10);
        total += 4;
        if (a_bytes.size() != 5) begin bad++; $display("[TB] FAIL rst_resend_count: got %0d expected 5", a_bytes.size()); end
        if (a_bytes[0] !== ASCII_LBRACE) begin bad++; $display("[TB] FAIL rst_resend_b0: got %h expected 7b", a_bytes[0]); end
        if (a_bytes[3] !== ASCII_LF) begin bad++; $display("[TB] FAIL rst_resend_b3: got %h expected 0a", a_bytes[3]); end
        if (a_bytes[4] !== ASCII_NUL) begin bad++; $display("[TB] FAIL rst_resend_term: got %h expected 00", a_bytes[4]); end
    endtask

    task automatic test_enable_stall();
        $display("[TB] sparse enable, ready held low, start while busy");
        set_a_byte(0, 8'h41);
        set_a_byte(1, 8'h42);
        set_a_byte(2, ASCII_HASH);
        a_len = 6'd3;
        clear_a();
        @(negedge clk);
        a_hold = 1'b1;
        en_toggle = 1'b1;
        a_start = 1'b1;
        idle_cycles(8);
        a_start = 1'b0;
        idle_cycles(12);
        total += 3;
        if (a_send_pulses != 0) begin bad++; $display("[TB] FAIL stall_no_send: got %0d expected 0", a_send_pulses); end
        if (a_busy !== 1'b1) begin bad++; $display("[TB] FAIL stall_busy: got %b expected 1", a_busy); end
        if (a_if.tx_send !== 1'b0) begin bad++; $display("[TB] FAIL stall_send_level: got %b expected 0", a_if.tx_send); end
        a_hold = 1'b0;
        for (int i = 0; i < 400 && a_bytes.size() < 2; i++) @(negedge clk);
        a_start = 1'b1;
        idle_cycles(8);
        a_start = 1'b0;
        for (int i = 0; i < 800 && a_dones < 1; i++) @(negedge clk);
        idle_cycles(40);
        total += 8;
        if (a_bytes.size() != 4) begin bad++; $display("[TB] FAIL stall_count: got %0d expected 4", a_bytes.size()); end
        if (a_bytes[0] !== 8'h41) begin bad++; $display("[TB] FAIL stall_b0: got %h expected 41", a_bytes[0]); end
        if (a_bytes[1] !== 8'h42) begin bad++; $display("[TB] FAIL stall_b1: got %h expected 42", a_bytes[1]); end
        if (a_bytes[2] !== ASCII_HASH) begin bad++; $display("[TB] FAIL stall_b2: got %h expected 23", a_bytes[2]); end
        if (a_bytes[3] !== ASCII_NUL) begin bad++; $display("[TB] FAIL stall_term: got %h expected 00", a_bytes[3]); end
        if (a_dones != 1) begin bad++; $display("[TB] FAIL stall_dones: got %0d expected 1", a_dones); end
        if (a_viol != 0) begin bad++; $display("[TB] FAIL stall_handshake_rules: got %0d violations expected 0", a_viol); end
        if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL stall_busy_end: got %b expected 0", a_busy); end
        en_toggle = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_zero_len();
        $display("[TB] zero-length messages");
        a_len = 6'd0;
        clear_a();
        pulse_a_start();
        for (int i = 0; i < 100 && a_dones < 1; i++) @(negedge clk);
        idle_cycles(10);
        total += 3;
        if (a_bytes.size() != 1) begin bad++; $display("[TB] FAIL zero_term_count: got %0d expected 1", a_bytes.size()); end
        if (a_bytes[0] !== ASCII_NUL) begin bad++; $display("[TB] FAIL zero_term_byte: got %h expected 00", a_bytes[0]); end
        if (a_dones != 1) begin bad++; $display("[TB] FAIL zero_term_done: got %0d expected 1", a_dones); end

        b_len = 6'd0;
        b_bytes.delete();
        b_dones = 0;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        total += 4;
        if (b_done !== 1'b1) begin bad++; $display("[TB] FAIL zero_noterm_done: got %b expected 1", b_done); end
        if (b_busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_noterm_busy: got %b expected 0", b_busy); end
        @(negedge clk);
        if (b_done !== 1'b0) begin bad++; $display("[TB] FAIL zero_noterm_done_pulse: got %b expected 0", b_done); end
        idle_cycles(10);
        if (b_bytes.size() != 0) begin bad++; $display("[TB] FAIL zero_noterm_sends: got %0d expected 0", b_bytes.size()); end
    endtask

    task automatic test_no_term();
        $display("[TB] unterminated message");
        b_msg[255 -: 8] = 8'h41;
        b_msg[247 -: 8] = 8'h42;
        b_len = 6'd2;
        b_bytes.delete();
        b_dones = 0;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        for (int i = 0; i < 200 && b_dones < 1; i++) @(negedge clk);
        idle_cycles(10);
        total += 4;
        if (b_bytes.size() != 2) begin bad++; $display("[TB] FAIL noterm_count: got %0d expected 2", b_bytes.size()); end
        if (b_bytes[0] !== 8'h41) begin bad++; $display("[TB] FAIL noterm_b0: got %h expected 41", b_bytes[0]); end
        if (b_bytes[1] !== 8'h42) begin bad++; $display("[TB] FAIL noterm_b1: got %h expected 42", b_bytes[1]); end
        if (b_dones != 1) begin bad++; $display("[TB] FAIL noterm_done: got %0d expected 1", b_dones); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_repeat_gap();
        test_reset_mid();
        test_enable_stall();
        test_zero_len();
        test_no_term();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
